// File: rtl/mem_stage_lsu_if.sv
// Request/grant/response data bus between the memory-access stage (master) and memory (slave).
interface mem_stage_lsu_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        gnt;
  logic        rvalid;
  logic [63:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-access stage: one-cycle pass-through or one bus transaction per instruction, registered
// writeback record. Defining LSU_MISALIGN_CHK_EN traps misaligned accesses instead of aligning them.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   ex_valid_i,
  output logic                   ex_ready_o,
  input  logic [63:0]            ex_alu_output_i,
  input  logic [63:0]            ex_store_data_i,
  input  logic                   ex_mem_rd_i,
  input  logic                   ex_mem_wr_i,
  input  logic [1:0]             ex_mem_size_i,
  input  logic                   ex_mem_unsigned_i,
  input  logic [4:0]             ex_rd_addr_i,
  input  logic                   ex_rd_wen_i,
  mem_stage_lsu_if.master        mem,
  output logic                   wb_valid_o,
  output logic [4:0]             wb_rd_addr_o,
  output logic                   wb_rd_wen_o,
  output logic [63:0]            wb_data_o,
  output logic                   wb_exc_o,
  output logic [1:0]             wb_exc_code_o
);
  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);
  localparam logic [1:0] ExcMisalign = 2'd1;
  localparam logic [1:0] ExcTimeout  = 2'd2;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        we_q, we_d, uns_q, uns_d, wen_q, wen_d;
  logic [2:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic [4:0]  rd_q, rd_d;

  logic        wb_valid_q, wb_valid_d, wb_rd_wen_q, wb_rd_wen_d, wb_exc_q, wb_exc_d;
  logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
  logic [63:0] wb_data_q, wb_data_d;
  logic [1:0]  wb_code_q, wb_code_d;

  logic [2:0]  align_mask, off_use;
  logic [7:0]  size_mask;
  logic [63:0] ld_shift, ld_data;
  logic        timeout;
`ifdef LSU_MISALIGN_CHK_EN
  logic        misalign;
`endif

  // Access-size decode of the incoming instruction.
  always_comb begin
    align_mask = 3'b000;
    size_mask  = 8'h01;
    unique case (ex_mem_size_i)
      2'd0: begin align_mask = 3'b000; size_mask = 8'h01; end
      2'd1: begin align_mask = 3'b001; size_mask = 8'h03; end
      2'd2: begin align_mask = 3'b011; size_mask = 8'h0F; end
      2'd3: begin align_mask = 3'b111; size_mask = 8'hFF; end
    endcase
`ifdef LSU_MISALIGN_CHK_EN
    off_use  = ex_alu_output_i[2:0];
    misalign = |(ex_alu_output_i[2:0] & align_mask);
`else
    off_use  = ex_alu_output_i[2:0] & ~align_mask;
`endif
  end

  always_comb begin
    ld_shift = mem.rdata >> {off_q, 3'b000};
    ld_data  = ld_shift;
    unique case (size_q)
      2'd0: ld_data = {{56{ld_shift[7]  & ~uns_q}}, ld_shift[7:0]};
      2'd1: ld_data = {{48{ld_shift[15] & ~uns_q}}, ld_shift[15:0]};
      2'd2: ld_data = {{32{ld_shift[31] & ~uns_q}}, ld_shift[31:0]};
      2'd3: ld_data = ld_shift;
    endcase
  end

  assign timeout = (cnt_q == TimeoutLast);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    we_d         = we_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wen_d        = wen_q;
    rd_d         = rd_q;
    wb_valid_d   = 1'b0;
    wb_rd_addr_d = 5'd0;
    wb_rd_wen_d  = 1'b0;
    wb_data_d    = 64'd0;
    wb_exc_d     = 1'b0;
    wb_code_d    = 2'd0;

    unique case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
        if (ex_valid_i) begin
          if (!ex_mem_rd_i && !ex_mem_wr_i) begin
            wb_valid_d   = 1'b1;
            wb_rd_addr_d = ex_rd_addr_i;
            wb_rd_wen_d  = ex_rd_wen_i;
            wb_data_d    = ex_alu_output_i;
`ifdef LSU_MISALIGN_CHK_EN
          end else if (misalign) begin
            wb_valid_d   = 1'b1;
            wb_rd_addr_d = ex_rd_addr_i;
            wb_data_d    = ex_alu_output_i;
            wb_exc_d     = 1'b1;
            wb_code_d    = ExcMisalign;
`endif
          end else begin
            addr_d  = {ex_alu_output_i[63:3], 3'b000};
            we_d    = ex_mem_wr_i;
            wdata_d = ex_mem_wr_i ? (ex_store_data_i << {off_use, 3'b000}) : 64'd0;
            wstrb_d = ex_mem_wr_i ? (size_mask << off_use) : 8'd0;
            off_d   = off_use;
            size_d  = ex_mem_size_i;
            uns_d   = ex_mem_unsigned_i;
            rd_d    = ex_rd_addr_i;
            wen_d   = ex_rd_wen_i;
            state_d = StReq;
          end
        end
      end
      StReq, StWait: begin
        cnt_d = cnt_q + 8'd1;
        // A completing handshake wins over a timeout in the same cycle.
        if (state_q == StReq && mem.gnt) begin
          if (we_q) begin
            state_d      = StIdle;
            wb_valid_d   = 1'b1;
            wb_rd_addr_d = rd_q;
          end else begin
            state_d = StWait;
          end
        end else if (state_q == StWait && mem.rvalid) begin
          state_d      = StIdle;
          wb_valid_d   = 1'b1;
          wb_rd_addr_d = rd_q;
          wb_rd_wen_d  = wen_q;
          wb_data_d    = ld_data;
        end else if (timeout) begin
          state_d      = StIdle;
          wb_valid_d   = 1'b1;
          wb_rd_addr_d = rd_q;
          wb_exc_d     = 1'b1;
          wb_code_d    = ExcTimeout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      wstrb_q      <= 8'd0;
      we_q         <= 1'b0;
      off_q        <= 3'd0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      wen_q        <= 1'b0;
      rd_q         <= 5'd0;
      wb_valid_q   <= 1'b0;
      wb_rd_addr_q <= 5'd0;
      wb_rd_wen_q  <= 1'b0;
      wb_data_q    <= 64'd0;
      wb_exc_q     <= 1'b0;
      wb_code_q    <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      we_q         <= we_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wen_q        <= wen_d;
      rd_q         <= rd_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_rd_wen_q  <= wb_rd_wen_d;
      wb_data_q    <= wb_data_d;
      wb_exc_q     <= wb_exc_d;
      wb_code_q    <= wb_code_d;
    end
  end

  assign ex_ready_o    = (state_q == StIdle);
  assign mem.req       = (state_q == StReq);
  assign mem.we        = we_q;
  assign mem.addr      = addr_q;
  assign mem.wdata     = wdata_q;
  assign mem.wstrb     = wstrb_q;
  assign wb_valid_o    = wb_valid_q;
  assign wb_rd_addr_o  = wb_rd_addr_q;
  assign wb_rd_wen_o   = wb_rd_wen_q;
  assign wb_data_o     = wb_data_q;
  assign wb_exc_o      = wb_exc_q;
  assign wb_exc_code_o = wb_code_q;
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-access stage directly downstream of the EX-stage ALU. It takes the ALU result as either a load/store address or a pass-through result. It runs a request/grant/response transaction on the 64-bit data bus and produces one registered writeback record per accepted instruction. Non-memory instructions pass through in one cycle; memory instructions stall EX until the bus transaction completes or times out.

## Interface
- `TIMEOUT_CYC`, default 255: cycles spent in REQ+WAIT before a bus-timeout exception; range 1..255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low.
- `ex_valid`  in  1  EX presents an instruction.
- `ex_ready`  out  1  high only in IDLE; a transfer occurs when `ex_valid & ex_ready`.
- `ex_alu_output`  in  64  ALU result: address for memory ops, writeback value otherwise.
- `ex_store_data`  in  64  rs2 value for stores.
- `ex_mem_rd` / `ex_mem_wr`  in  1 each  load / store; never both high.
- `ex_mem_size`  in  2  0=B, 1=H, 2=W, 3=D.
- `ex_mem_unsigned`  in  1  zero-extend load (LBU/LHU/LWU).
- `ex_rd_addr`  in  5 and `ex_rd_wen`  in  1  destination register and write enable.
- `mem_req`  out  1  bus request, held until `mem_gnt`.
- `mem_we`  out  1  store.
- `mem_addr`  out  64  doubleword address; bits [2:0] = 0.
- `mem_wdata`  out  64  lane-aligned store data.
- `mem_wstrb`  out  8  byte enables; 0 for loads.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  load data valid.
- `mem_rdata`  in  64  load data, whole doubleword.
- `wb_valid`  out  1  one-cycle pulse per completed instruction.
- `wb_rd_addr`  out  5, `wb_rd_wen`  out  1, `wb_data`  out  64  writeback record.
- `wb_exc`  out  1 and `wb_exc_code`  out  2  exception flag; code 1 = misaligned, 2 = bus timeout.

## Operation
- **States:**
  - IDLE.
  - REQ: `mem_req` high.
  - WAIT: load awaiting `mem_rvalid`.
- **IDLE, transfer with neither `ex_mem_rd` nor `ex_mem_wr`:**
  - Next cycle `wb_valid`=1 with `wb_data=ex_alu_output` and the given rd/wen.
  - State stays IDLE, so throughput is 1 per cycle.
- **IDLE, transfer with a memory op:**
  - Latch the fields. `off = addr[2:0]`.
  - `mem_addr = {addr[63:3],3'b0}`.
  - Store: `mem_wdata = ex_store_data << (8*off)`, `mem_wstrb = sizemask << off`, where sizemask is 0x01/0x03/0x0F/0xFF.
  - Go to REQ.
- **REQ:**
  - On `mem_gnt` for a store: go to IDLE, `wb_valid` next cycle with `wb_rd_wen`=0.
  - On `mem_gnt` for a load: go to WAIT.
  - `mem_rvalid` is ignored in REQ.
- **WAIT, on `mem_rvalid`:**
  - `d = mem_rdata >> (8*off)`.
  - Truncate `d` to the access size, then sign- or zero-extend to 64 bits.
  - `wb_valid` next cycle with `wb_data = d`. Go to IDLE.
- **Timeout:**
  - An 8-bit counter clears when entering REQ and increments each cycle in REQ or WAIT.
  - At count = `TIMEOUT_CYC`: drop `mem_req`, go to IDLE.
  - Next cycle `wb_valid`=1, `wb_exc`=1, code 2, `wb_rd_wen`=0, `wb_data`=0.
- **Stray responses:** `mem_rvalid` or `mem_gnt` arriving in IDLE is ignored.
- **Exceptions:** `wb_exc` is 0 except on the paths above and under the configuration macro.

## Timing
- **Reset values** (async, while `rst`=0): state IDLE, counter 0, and the following outputs:
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` = 0.
  - `wb_valid`, `wb_rd_addr`, `wb_rd_wen`, `wb_data`, `wb_exc`, `wb_exc_code` = 0.
  - `ex_ready` = 1.
- **Mid-transaction reset:** aborts immediately. `mem_req` falls asynchronously and no writeback is produced.
- **`mem_req` timing:** registered; first high the cycle after the transfer. `mem_addr`/`mem_we`/`mem_wdata`/`mem_wstrb` are stable while `mem_req` is high.
- **Latency**, with the transfer at edge T:
  - Pass-through: `wb_valid` at T+1.
  - Store with immediate grant: `wb_valid` at T+2.
  - Load with grant at T+1 and rvalid at T+2: `wb_valid` at T+3.
- **Backpressure:** `ex_ready` is low in REQ and WAIT. `ex_ready` rises in the same cycle `wb_valid` rises for a memory op.
- **Writeback:** `wb_*` are registered and there is no writeback backpressure.

## Configuration
- **`LSU_MISALIGN_CHK_EN` defined:** the check applies when `off` is not a multiple of the access size (H: off[0]; W: off[1:0]; D: off[2:0]).
  - No bus request is issued and state stays IDLE.
  - `wb_valid` next cycle with `wb_exc`=1, code 1, `wb_rd_wen`=0.
  - `wb_data` = faulting address.
- **Not defined:** `off` low bits below the access size are cleared (H clears bit 0, W bits [1:0], D bits [2:0]) and the access proceeds normally. Code 1 never occurs.

## Test plan
- Pass-through: 3 back-to-back transfers with `ex_alu_output`=0x11, 0x22, 0x33, rd=5 -> `wb_valid` on three consecutive cycles with `wb_data` 0x11, 0x22, 0x33 and `ex_ready` constantly 1.
- Store SH to addr 0x1006, data 0xABCD, grant after 2 cycles:
  - `mem_addr`=0x1000, `mem_wstrb`=0xC0, `mem_wdata`[63:48]=0xABCD.
  - `wb_valid` with `wb_rd_wen`=0 one cycle after grant.
- Load LB at addr 0x2003, `mem_rdata`=0x0000_0000_8000_0000 -> `wb_data`=0xFFFF_FFFF_FFFF_FF80. LBU gives 0x80.
- Timeout: `TIMEOUT_CYC`=4, load never granted -> `mem_req` high for 4 cycles then low; `wb_exc`=1, code 2; a later stray `mem_rvalid` produces nothing.
- Misalign: LW at 0x3002.
  - With `LSU_MISALIGN_CHK_EN`: no `mem_req`; `wb_exc`=1, code 1, `wb_data`=0x3002.
  - Without it: `mem_wstrb`=0 and data is taken from lane offset 0.
- `rst` low while in WAIT -> `mem_req`/`wb_valid` 0 immediately, `ex_ready`=1; after release a new pass-through instruction completes in 1 cycle.
